warmboot_sequencer: RTL and testbench

- Controller behind the warm-boot tile's BOOT and SLOT0..3 routing outputs; sequences a fabric warm reconfiguration.
- Synchronises and debounces the fabric-driven boot request, then latches the selected bitstream slot.
- Holds the fabric in reset while it pulses the reconfiguration trigger to the configuration controller.
- Locks out re-triggering until the request is released.

---
 rtl/warmboot_sequencer.sv | 146 ++++++++++++++
 tb/tb_warmboot_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/warmboot_sequencer.sv
// rtl/warmboot_sequencer.sv - warm-boot reconfiguration sequencer; optional macro WARMBOOT_SLOT_STABLE_EN restarts the hold count when the slot changes during qualification
module warmboot_sequencer #(
    parameter int HOLD_CYCLES  = 16,
    parameter int RESET_CYCLES = 8,
    parameter int TRIG_CYCLES  = 4,
    parameter int NUM_SLOTS    = 4
) (
    input  logic       CLK,
    input  logic       resetn,
    input  logic       boot_i,
    input  logic [3:0] slot_i,
    output logic       trigger_o,
    output logic [3:0] slot_o,
    output logic       fabric_reset_o,
    output logic       busy_o,
    output logic       err_o
);
    localparam int MAX_HR  = (HOLD_CYCLES > RESET_CYCLES) ? HOLD_CYCLES : RESET_CYCLES;
    localparam int MAX_CYC = (MAX_HR > TRIG_CYCLES) ? MAX_HR : TRIG_CYCLES;
    localparam int CNT_W   = (MAX_CYC < 2) ? 1 : $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_DRAIN,
        S_TRIG,
        S_LOCK
    } state_t;

    logic             r_boot_m;
    logic             r_boot_s;
    logic [3:0]       r_slot_m;
    logic [3:0]       r_slot_s;
    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_capture;
    logic             w_err_set;
    logic             w_err_clr;
    logic             w_slot_invalid;

    assign w_slot_invalid = ({1'b0, r_slot_s} >= 5'(NUM_SLOTS));

`ifdef WARMBOOT_SLOT_STABLE_EN
    // Reference slot: the synchronised slot one cycle ago, so any change is seen as a restart
    logic [3:0] r_slot_ref;
    always_ff @(posedge CLK) begin
        if (!resetn) r_slot_ref <= '0;
        else         r_slot_ref <= r_slot_s;
    end
`endif

    // Two-flop synchronisers for the asynchronous boot request and slot index
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            r_boot_m <= 1'b0;
            r_boot_s <= 1'b0;
            r_slot_m <= '0;
            r_slot_s <= '0;
        end else begin
            r_boot_m <= boot_i;
            r_boot_s <= r_boot_m;
            r_slot_m <= slot_i;
            r_slot_s <= r_slot_m;
        end
    end

    // State and shared counter registers
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state, counter and capture/flag decisions; counter clears on every state change
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        w_capture  = 1'b0;
        w_err_set  = 1'b0;
        w_err_clr  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_boot_s) begin
                    w_next    = S_ARM;
                    w_err_clr = 1'b1;
                end
            end
            S_ARM: begin
                if (!r_boot_s) begin
                    w_next = S_IDLE;
`ifdef WARMBOOT_SLOT_STABLE_EN
                end else if (r_slot_s != r_slot_ref) begin
                    w_cnt_next = '0;
`endif
                end else if (r_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                    w_capture = 1'b1;
                    if (w_slot_invalid) begin
                        w_err_set = 1'b1;
                        w_next    = S_LOCK;
                    end else begin
                        w_next    = S_DRAIN;
                    end
                end else begin
                    w_cnt_next = r_cnt + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                if (r_cnt == CNT_W'(RESET_CYCLES - 1)) w_next = S_TRIG;
                else                                   w_cnt_next = r_cnt + CNT_W'(1);
            end
            S_TRIG: begin
                if (r_cnt == CNT_W'(TRIG_CYCLES - 1)) w_next = S_LOCK;
                else                                  w_cnt_next = r_cnt + CNT_W'(1);
            end
            S_LOCK: begin
                if (!r_boot_s) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
        if (w_next != r_state) w_cnt_next = '0;
    end

    // Registered outputs decoded from the next state so they line up with the state register
    always_ff @(posedge CLK) begin
        if (!resetn) begin
            trigger_o      <= 1'b0;
            fabric_reset_o <= 1'b0;
            busy_o         <= 1'b0;
            slot_o         <= '0;
            err_o          <= 1'b0;
        end else begin
            trigger_o      <= (w_next == S_TRIG);
            fabric_reset_o <= (w_next == S_DRAIN) || (w_next == S_TRIG);
            busy_o         <= (w_next != S_IDLE);
            if (w_capture) slot_o <= r_slot_s;
            if (w_err_set)      err_o <= 1'b1;
            else if (w_err_clr) err_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_warmboot_sequencer.sv
// tb/tb_warmboot_sequencer.sv - self-checking bench for warmboot_sequencer
module tb_warmboot_sequencer;
    localparam int HOLD = 16;
    localparam int RST  = 8;
    localparam int TRG  = 4;
    localparam int NS   = 4;

    logic       CLK    = 1'b0;
    logic       resetn = 1'b0;
    logic       boot_i = 1'b0;
    logic [3:0] slot_i = 4'd0;
    logic       trigger_o;
    logic [3:0] slot_o;
    logic       fabric_reset_o;
    logic       busy_o;
    logic       err_o;

    int n_tests = 0;
    int n_fail  = 0;

    warmboot_sequencer #(
        .HOLD_CYCLES (HOLD),
        .RESET_CYCLES(RST),
        .TRIG_CYCLES (TRG),
        .NUM_SLOTS   (NS)
    ) dut (
        .CLK           (CLK),
        .resetn        (resetn),
        .boot_i        (boot_i),
        .slot_i        (slot_i),
        .trigger_o     (trigger_o),
        .slot_o        (slot_o),
        .fabric_reset_o(fabric_reset_o),
        .busy_o        (busy_o),
        .err_o         (err_o)
    );

    always #5 CLK = ~CLK;

    // Timeline model: a request starts on the edge boot_s is first seen, qualifies
    // HOLD edges later, then reset/trigger windows are fixed offsets from qualification.
    logic       m_b1 = 0, m_b2 = 0;
    logic [3:0] m_s1 = 0, m_s2 = 0, m_sprev = 0;
    int         m_cyc = 0, m_start = -1, m_qual = -1;
    bit         m_valid = 0;
    logic [3:0] m_slot = 0;
    logic       m_err = 0;

    int   n_trig_hi = 0, n_frst_hi = 0, n_rise = 0;
    logic prev_trig = 0;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, m_cyc);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_step();
        logic       b;
        logic [3:0] s;
        int         lock_at;
        m_cyc++;
        if (!resetn) begin
            m_b1 = 0; m_b2 = 0; m_s1 = 0; m_s2 = 0; m_sprev = 0;
            m_start = -1; m_qual = -1; m_valid = 0; m_slot = 0; m_err = 0;
        end else begin
            b = m_b2;
            s = m_s2;
            if (m_start < 0) begin
                if (b) begin
                    m_start = m_cyc;
                    m_err   = 0;
                end
            end else if (m_qual < 0) begin
                if (!b) m_start = -1;
`ifdef WARMBOOT_SLOT_STABLE_EN
                else if (s != m_sprev) m_start = m_cyc;
`endif
                else if (m_cyc - m_start == HOLD) begin
                    m_qual  = m_cyc;
                    m_slot  = s;
                    m_valid = (s < NS);
                    if (!m_valid) m_err = 1;
                end
            end else begin
                lock_at = m_valid ? (RST + TRG + 1) : 1;
                if (!b && (m_cyc - m_qual >= lock_at)) begin
                    m_start = -1;
                    m_qual  = -1;
                end
            end
            m_sprev = s;
            m_b2 = m_b1; m_b1 = boot_i;
            m_s2 = m_s1; m_s1 = slot_i;
        end
    endtask

    // Compare DUT against the model away from the active edge, then advance the model
    always @(negedge CLK) begin
        automatic int   e    = m_cyc - m_qual;
        automatic logic q    = (m_qual >= 0);
        automatic logic mtr  = q && m_valid && (e >= RST) && (e < RST + TRG);
        automatic logic mfr  = q && m_valid && (e < RST + TRG);
        chk("trigger_o", {3'b0, trigger_o}, {3'b0, mtr});
        chk("fabric_reset_o", {3'b0, fabric_reset_o}, {3'b0, mfr});
        chk("busy_o", {3'b0, busy_o}, {3'b0, m_start >= 0});
        chk("err_o", {3'b0, err_o}, {3'b0, m_err});
        chk("slot_o", slot_o, m_slot);
        if (trigger_o === 1'b1) n_trig_hi++;
        if (fabric_reset_o === 1'b1) n_frst_hi++;
        if (trigger_o === 1'b1 && prev_trig !== 1'b1) n_rise++;
        prev_trig = trigger_o;
        model_step();
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic clr_counts();
        n_trig_hi = 0; n_frst_hi = 0; n_rise = 0;
    endtask

    // Edges from the current point until trigger_o is seen high; bounded
    task automatic wait_trig(output int lat);
        lat = 0;
        do begin
            tick(1);
            lat++;
        end while (trigger_o !== 1'b1 && lat < 120);
        if (trigger_o !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_trig: trigger_o never rose within %0d cycles", lat);
        end
    endtask

    initial begin
        int lat;
        resetn = 0;
        tick(3);
        chk("reset_busy", {3'b0, busy_o}, 4'd0);
        chk("reset_slot", slot_o, 4'd0);
        resetn = 1;
        tick(2);

        // Basic boot, slot 2
        clr_counts();
        slot_i = 4'd2;
        boot_i = 1;
        wait_trig(lat);
        chk_int("basic_latency", lat, 27);
        tick(40);
        chk("basic_slot", slot_o, 4'd2);
        chk("basic_busy_held", {3'b0, busy_o}, 4'd1);
        chk_int("basic_trig_width", n_trig_hi, 4);
        chk_int("basic_reset_width", n_frst_hi, 12);
        boot_i = 0;
        tick(4);
        chk("basic_idle", {3'b0, busy_o}, 4'd0);

        // Glitch rejection
        clr_counts();
        slot_i = 4'd1;
        boot_i = 1;
        tick(10);
        boot_i = 0;
        tick(10);
        chk_int("glitch_reset", n_frst_hi, 0);
        chk_int("glitch_trig", n_trig_hi, 0);
        chk("glitch_busy", {3'b0, busy_o}, 4'd0);
        chk("glitch_slot", slot_o, 4'd2);

        // Invalid slot
        clr_counts();
        slot_i = 4'd5;
        boot_i = 1;
        tick(30);
        chk("inv_err", {3'b0, err_o}, 4'd1);
        chk("inv_slot", slot_o, 4'd5);
        chk_int("inv_reset", n_frst_hi, 0);
        chk_int("inv_trig", n_trig_hi, 0);
        boot_i = 0;
        tick(5);
        chk("inv_err_sticky", {3'b0, err_o}, 4'd1);
        slot_i = 4'd1;
        boot_i = 1;
        tick(3);
        chk("inv_err_clear", {3'b0, err_o}, 4'd0);
        tick(40);
        chk("inv_next_slot", slot_o, 4'd1);
        boot_i = 0;
        tick(5);

        // No retrigger while held, full sequence after release
        clr_counts();
        slot_i = 4'd3;
        boot_i = 1;
        tick(200);
        chk_int("hold_one_pulse", n_rise, 1);
        boot_i = 0;
        tick(5);
        clr_counts();
        boot_i = 1;
        tick(40);
        chk_int("reassert_pulse", n_rise, 1);
        chk_int("reassert_width", n_trig_hi, 4);
        boot_i = 0;
        tick(5);

        // Reset during the second trigger cycle
        slot_i = 4'd2;
        boot_i = 1;
        wait_trig(lat);
        tick(1);
        chk("rst_mid_trig_pre", {3'b0, trigger_o}, 4'd1);
        resetn = 0;
        tick(1);
        chk("rst_trig", {3'b0, trigger_o}, 4'd0);
        chk("rst_frst", {3'b0, fabric_reset_o}, 4'd0);
        chk("rst_busy", {3'b0, busy_o}, 4'd0);
        chk("rst_slot", slot_o, 4'd0);
        boot_i = 0;
        resetn = 1;
        tick(5);

        // Slot change at ARM cycle 10
        slot_i = 4'd1;
        boot_i = 1;
        tick(13);
        slot_i = 4'd3;
        lat = 0;
        begin
            int rest;
            wait_trig(rest);
            lat = 13 + rest;
        end
`ifdef WARMBOOT_SLOT_STABLE_EN
        chk_int("slot_change_latency", lat, 40);
`else
        chk_int("slot_change_latency", lat, 27);
`endif
        chk("slot_change_slot", slot_o, 4'd3);
        boot_i = 0;
        tick(30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
